// File: rtl/slot_round_controller.sv
// slot_round_controller: one slot-machine round (debit, spin, evaluate, pay).
// Owns the player score and the progressive jackpot pool. Every output is
// either a register or decoded from the state register.
module slot_round_controller #(
  parameter int SCORE_W      = 17,
  parameter int SINGLE_COST  = 10,
  parameter int MAX_COST     = 50,
  parameter int WIN_SINGLE   = 200,
  parameter int WIN_MAX      = 1000,
  parameter int START_SCORE  = 1000,
  parameter int JACKPOT_SEED = 5000,
  parameter int SPIN_TIMEOUT = 1023
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               play_req_i,
  input  logic               bet_max_i,
  output logic               spin_start_o,
  input  logic               spin_done_i,
  input  logic [11:0]        spin_value_i,
  output logic               busy_o,
  output logic               reject_o,
  output logic               result_valid_o,
  output logic [1:0]         result_type_o,
  output logic [SCORE_W-1:0] payout_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [SCORE_W-1:0] jackpot_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DEBIT  = 3'd1;
  localparam logic [2:0] S_SPIN   = 3'd2;
  localparam logic [2:0] S_EVAL   = 3'd3;
  localparam logic [2:0] S_PAYOUT = 3'd4;

  localparam logic [1:0] R_LOSS  = 2'b00;
  localparam logic [1:0] R_WIN   = 2'b01;
  localparam logic [1:0] R_ABORT = 2'b10;
  localparam logic [1:0] R_JACK  = 2'b11;

  localparam int CNT_W = $clog2(SPIN_TIMEOUT + 1);

  localparam logic [SCORE_W-1:0] C_SINGLE = SCORE_W'(SINGLE_COST);
  localparam logic [SCORE_W-1:0] C_MAX    = SCORE_W'(MAX_COST);
  localparam logic [SCORE_W-1:0] W_SINGLE = SCORE_W'(WIN_SINGLE);
  localparam logic [SCORE_W-1:0] W_MAX    = SCORE_W'(WIN_MAX);
  localparam logic [SCORE_W-1:0] V_START  = SCORE_W'(START_SCORE);
  localparam logic [SCORE_W-1:0] V_SEED   = SCORE_W'(JACKPOT_SEED);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SPIN_TIMEOUT - 1);

  logic [2:0]         state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] jackpot_q, jackpot_d;
  logic [SCORE_W-1:0] payout_q, payout_d;
  logic [1:0]         rtype_q, rtype_d;
  logic               bet_max_q, bet_max_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [11:0]        spin_q, spin_d;
  logic               spin_start_q, spin_start_d;
  logic               reject_q, reject_d;
  logic               rvalid_q, rvalid_d;

  logic [SCORE_W-1:0] req_cost, cost;
  logic [3:0]         d2, d1, d0;
  logic               triple, jack_hit;

  // Add two unsigned values, clamping at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  // Subtract, clamping at zero instead of wrapping.
  function automatic logic [SCORE_W-1:0] sub_floor(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
    return (a < b) ? '0 : (a - b);
  endfunction

  assign req_cost = bet_max_i ? C_MAX : C_SINGLE;
  assign cost     = bet_max_q ? C_MAX : C_SINGLE;
  assign d2       = spin_q[11:8];
  assign d1       = spin_q[7:4];
  assign d0       = spin_q[3:0];
  // Non-BCD digits take part in the triple test like any other value.
  assign triple   = (d2 == d1) && (d1 == d0);
  assign jack_hit = triple && (d0 == 4'h7) && bet_max_q;

  // Next-state and datapath for the round sequencer.
  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    jackpot_d    = jackpot_q;
    payout_d     = payout_q;
    rtype_d      = rtype_q;
    bet_max_d    = bet_max_q;
    cnt_d        = cnt_q;
    spin_d       = spin_q;
    spin_start_d = 1'b0;
    reject_d     = 1'b0;
    rvalid_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (play_req_i) begin
          if (score_q < req_cost) begin
            reject_d = 1'b1;
          end else begin
            bet_max_d = bet_max_i;
            state_d   = S_DEBIT;
          end
        end
      end
      S_DEBIT: begin
        score_d      = score_q - cost;
        jackpot_d    = sat_add(jackpot_q, cost);
        cnt_d        = '0;
        spin_start_d = 1'b1;
        state_d      = S_SPIN;
      end
      S_SPIN: begin
        if (spin_done_i) begin
          spin_d  = spin_value_i;
          state_d = S_EVAL;
        end else if (cnt_q == CNT_LAST) begin
          // Reel block never answered: undo the debit and report an abort.
          score_d   = sat_add(score_q, cost);
          jackpot_d = sub_floor(jackpot_q, cost);
          rtype_d   = R_ABORT;
          payout_d  = '0;
          rvalid_d  = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EVAL: begin
        if (jack_hit) begin
          rtype_d  = R_JACK;
          payout_d = jackpot_q;
        end else if (triple) begin
          rtype_d  = R_WIN;
          payout_d = bet_max_q ? W_MAX : W_SINGLE;
        end else begin
          rtype_d  = R_LOSS;
          payout_d = '0;
        end
        rvalid_d = 1'b1;
        state_d  = S_PAYOUT;
      end
      S_PAYOUT: begin
        score_d = sat_add(score_q, payout_q);
        if (rtype_q == R_JACK) jackpot_d = V_SEED;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any round in flight.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      score_q      <= V_START;
      jackpot_q    <= V_SEED;
      payout_q     <= '0;
      rtype_q      <= R_LOSS;
      bet_max_q    <= 1'b0;
      cnt_q        <= '0;
      spin_q       <= '0;
      spin_start_q <= 1'b0;
      reject_q     <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      jackpot_q    <= jackpot_d;
      payout_q     <= payout_d;
      rtype_q      <= rtype_d;
      bet_max_q    <= bet_max_d;
      cnt_q        <= cnt_d;
      spin_q       <= spin_d;
      spin_start_q <= spin_start_d;
      reject_q     <= reject_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign spin_start_o   = spin_start_q;
  assign reject_o       = reject_q;
  assign result_valid_o = rvalid_q;
  assign result_type_o  = rtype_q;
  assign payout_o       = payout_q;
  assign score_o        = score_q;
  assign jackpot_o      = jackpot_q;

endmodule

// File: tb/tb_slot_round_controller.sv
// Bench for slot_round_controller: directed table, drain/reject and timeout
// sequences, then random rounds against a round-level reference model.
module tb_slot_round_controller;
  localparam int W    = 17;
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst, play_req, bet_max, spin_done;
  logic [11:0]   spin_value;
  logic          spin_start, busy, reject, result_valid;
  logic [1:0]    result_type;
  logic [W-1:0]  payout, score, jackpot;

  slot_round_controller dut (
    .clock_i(clk), .reset_i(rst), .play_req_i(play_req), .bet_max_i(bet_max),
    .spin_start_o(spin_start), .spin_done_i(spin_done), .spin_value_i(spin_value),
    .busy_o(busy), .reject_o(reject), .result_valid_o(result_valid),
    .result_type_o(result_type), .payout_o(payout), .score_o(score), .jackpot_o(jackpot)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_score, m_jp;

  typedef struct {
    bit          rst_first;
    bit          bet;
    logic [11:0] val;
    int          delay;
    int          exp_type;
    int          exp_pay;
    int          exp_score;
    int          exp_jp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Round-level model: whole-round effect on score/jackpot from the rules.
  task automatic model_round(input bit bet, input logic [11:0] v,
                             output int typ, output int pay);
    int cost;
    cost = bet ? 50 : 10;
    m_score = m_score - cost;
    m_jp = (m_jp + cost > MAXV) ? MAXV : m_jp + cost;
    if (v[11:8] == v[7:4] && v[7:4] == v[3:0]) begin
      if (bet && v[3:0] == 4'h7) begin typ = 3; pay = m_jp; m_jp = 5000; end
      else begin typ = 1; pay = bet ? 1000 : 200; end
    end else begin
      typ = 0; pay = 0;
    end
    m_score = (m_score + pay > MAXV) ? MAXV : m_score + pay;
  endtask

  task automatic do_reset();
    rst = 1'b1; play_req = 1'b0; spin_done = 1'b0; bet_max = 1'b0; spin_value = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    m_score = 1000; m_jp = 5000;
  endtask

  // Full round with exact cycle timing; called at a negedge while IDLE.
  task automatic do_round(input bit bet, input logic [11:0] v, input int delay, input bit noise,
                          input int etype, input int epay, input int escore, input int ejp);
    play_req = 1'b1; bet_max = bet;
    @(negedge clk);                       // DEBIT
    chk("busy_debit", busy, 1);
    chk("spin_start_debit", spin_start, 0);
    if (noise) begin
      spin_done = 1'b1; spin_value = 12'h777; bet_max = ~bet;   // all ignored here
    end else play_req = 1'b0;
    @(negedge clk);                       // first SPIN cycle
    play_req = 1'b0; spin_done = 1'b0;
    chk("spin_start_pulse", spin_start, 1);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("spin_start_once", spin_start, 0);
    end
    spin_done = 1'b1; spin_value = v;
    @(negedge clk);                       // EVAL
    spin_done = 1'b0; spin_value = 12'($urandom);
    chk("rvalid_eval", result_valid, 0);
    @(negedge clk);                       // PAYOUT
    chk("rvalid_payout", result_valid, 1);
    chk("result_type", result_type, etype);
    chk("payout", payout, epay);
    @(negedge clk);                       // back in IDLE
    chk("rvalid_clear", result_valid, 0);
    chk("busy_idle", busy, 0);
    chk("score", score, escore);
    chk("jackpot", jackpot, ejp);
  endtask

  task automatic model_and_round(input bit bet, input logic [11:0] v, input int delay, input bit noise);
    int t, p;
    model_round(bet, v, t, p);
    do_round(bet, v, delay, noise, t, p, m_score, m_jp);
  endtask

  task automatic try_reject(input bit bet);
    play_req = 1'b1; bet_max = bet;
    @(negedge clk);
    play_req = 1'b0;
    chk("reject_pulse", reject, 1);
    chk("reject_busy", busy, 0);
    @(negedge clk);
    chk("reject_clear", reject, 0);
    chk("reject_busy2", busy, 0);
    chk("reject_score", score, m_score);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 12'h123, 0, 0, 0,    990,  5010};
    tbl[1] = '{1'b1, 1'b1, 12'h444, 2, 1, 1000, 1950, 5050};
    tbl[2] = '{1'b0, 1'b1, 12'h777, 1, 3, 5100, 7000, 5000};
    tbl[3] = '{1'b0, 1'b0, 12'h777, 0, 1, 200,  7190, 5010};
    tbl[4] = '{1'b0, 1'b0, 12'hAAA, 3, 1, 200,  7380, 5020};
    tbl[5] = '{1'b0, 1'b1, 12'h772, 0, 0, 0,    7330, 5070};
    tbl[6] = '{1'b0, 1'b1, 12'hF7F, 4, 0, 0,    7280, 5120};
    tbl[7] = '{1'b0, 1'b1, 12'h000, 0, 1, 1000, 8230, 5170};

    do_reset();
    chk("rst_score", score, 1000);
    chk("rst_jackpot", jackpot, 5000);
    chk("rst_busy", busy, 0);
    chk("rst_type", result_type, 0);
    chk("rst_payout", payout, 0);
    chk("rst_rvalid", result_valid, 0);
    chk("rst_spin_start", spin_start, 0);

    // Directed table; consecutive rows run back-to-back.
    foreach (tbl[i]) begin
      if (tbl[i].rst_first) do_reset();
      do_round(tbl[i].bet, tbl[i].val, tbl[i].delay, 1'b0,
               tbl[i].exp_type, tbl[i].exp_pay, tbl[i].exp_score, tbl[i].exp_jp);
    end

    // Drain to zero with losing max bets; the last one is accepted at score==cost.
    do_reset();
    for (int i = 0; i < 20; i++) model_and_round(1'b1, 12'h123, 0, 1'b0);
    chk("drained_score", score, 0);
    try_reject(1'b1);
    try_reject(1'b0);

    // Spin timeout: abort after SPIN_TIMEOUT SPIN cycles, refund cost.
    do_reset();
    begin
      int n;
      play_req = 1'b1; bet_max = 1'b1;
      @(negedge clk); play_req = 1'b0;
      @(negedge clk);
      chk("to_spin_start", spin_start, 1);
      n = 1;
      while (!result_valid && n < 1100) begin @(negedge clk); n++; end
      chk("to_abort_seen", result_valid, 1);
      chk("to_latency", n, 1024);
      chk("to_type", result_type, 2);
      chk("to_payout", payout, 0);
      @(negedge clk);
      chk("to_score", score, 1000);
      chk("to_jackpot", jackpot, 5000);
      chk("to_busy", busy, 0);
      chk("to_type_held", result_type, 2);
    end

    // Reset while spinning discards the round without refund semantics.
    model_and_round(1'b0, 12'h555, 1, 1'b0);
    play_req = 1'b1; bet_max = 1'b1;
    @(negedge clk); play_req = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("mid_busy", busy, 1);
    do_reset();
    chk("midrst_busy", busy, 0);
    chk("midrst_score", score, 1000);
    chk("midrst_jackpot", jackpot, 5000);
    chk("midrst_type", result_type, 0);
    @(negedge clk);
    chk("midrst_spin_start", spin_start, 0);

    // Random rounds against the model.
    do_reset();
    for (int r = 0; r < 120; r++) begin
      bit b;
      logic [11:0] v;
      logic [3:0] d;
      b = 1'($urandom);
      case ($urandom % 4)
        0: v = 12'h777;
        1: begin d = 4'($urandom); v = {d, d, d}; end
        default: v = 12'($urandom);
      endcase
      if (m_score < (b ? 50 : 10)) try_reject(b);
      else model_and_round(b, v, int'($urandom % 6), 1'($urandom));
      if ($urandom % 3 == 0) begin
        spin_done = 1'b1; spin_value = 12'h777;   // spin_done outside SPIN
        @(negedge clk);
        spin_done = 1'b0;
        chk("idle_noise_busy", busy, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
